exec_stage_mc: RTL and testbench

Parametrised execute stage with an EX/MEM pipeline register, valid/ready flow control, flush support and an iterative multi-cycle multiplier. It sits between the ID/EX register and the memory stage. It replaces the fixed-width, always-advancing execute stage. Single-cycle ALU ops complete in one cycle. MUL occupies the stage for XLEN cycles. The output register holds its contents under back-pressure from the memory stage.

---
 rtl/exec_pkg.sv | 31 +++
 rtl/exec_stage_mc_iter_mul.sv | 71 +++++++
 rtl/exec_stage_mc.sv | 244 ++++++++++++++++++++++++
 tb/tb_exec_stage_mc.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage.
// Provides the ALU operation codes, the multiplier FSM state encoding and
// the packed bundle of decode control bits that travels with each op into
// the EX/MEM output register.
package exec_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic reg_write;
        logic branch;
        logic uncond_branch;
        logic mem_read;
        logic mem_write;
        logic mem2reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/exec_stage_mc_iter_mul.sv
// Iterative shift-add multiplier, one partial product per clock.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   start         load a/b and begin XLEN steps
//   kill          abandon the current multiply (count and accumulator cleared)
//   a, b          multiplicand and multiplier
//   done          count has reached zero (result in product is final)
//   product       low XLEN bits of a*b (unsigned)
module iter_mul #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;

    // One step per cycle while count is non-zero: add the shifted
    // multiplicand when the current multiplier LSB is set.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (kill) begin
            acc_d   = '0;
            count_d = '0;
        end else if (start) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            count_d  = CNT_W'(XLEN);
        end else if (count_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    assign done    = (count_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage with EX/MEM output register, valid/ready handshake, flush
// and an iterative multiplier.
// Ports:
//   clk, reset, flush          clock, async active-high reset, branch kill
//   in_valid / in_ready        handshake from the ID/EX register
//   reg_write..alu_src, alu_op decode control and operation code
//   rd, reg_a, reg_b, imm, pc  destination and operands
//   out_valid / out_ready      handshake to the memory stage
//   *_m                        registered control, result, store data, target
//   busy                       multiplier occupies the stage
module exec_stage_mc
    import exec_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int RA_W   = 5,
    parameter int OP_W   = 4,
    parameter int MUL_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            reg_write,
    input  logic            branch,
    input  logic            uncond_branch,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem2reg,
    input  logic            alu_src,
    input  logic [OP_W-1:0] alu_op,
    input  logic [RA_W-1:0] rd,
    input  logic [XLEN-1:0] reg_a,
    input  logic [XLEN-1:0] reg_b,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            reg_write_m,
    output logic            branch_m,
    output logic            uncond_branch_m,
    output logic            mem_read_m,
    output logic            mem_write_m,
    output logic            mem2reg_m,
    output logic            alu_zero_m,
    output logic [RA_W-1:0] rd_m,
    output logic [XLEN-1:0] alu_out_m,
    output logic [XLEN-1:0] reg_b_m,
    output logic [XLEN-1:0] pc_target_m,
    output logic            busy
);

    localparam logic [OP_W-1:0] C_AND   = OP_W'(OP_AND);
    localparam logic [OP_W-1:0] C_OR    = OP_W'(OP_OR);
    localparam logic [OP_W-1:0] C_ADD   = OP_W'(OP_ADD);
    localparam logic [OP_W-1:0] C_SUB   = OP_W'(OP_SUB);
    localparam logic [OP_W-1:0] C_PASSB = OP_W'(OP_PASSB);
    localparam logic [OP_W-1:0] C_MUL   = OP_W'(OP_MUL);

    state_t          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    ctrl_t           ctrl_m_q, ctrl_m_d;
    logic            zero_m_q, zero_m_d;
    logic [RA_W-1:0] rd_m_q, rd_m_d;
    logic [XLEN-1:0] alu_m_q, alu_m_d;
    logic [XLEN-1:0] regb_m_q, regb_m_d;
    logic [XLEN-1:0] tgt_m_q, tgt_m_d;

    // Side-band fields of a multiply, held while the multiplier iterates.
    ctrl_t           ctrl_l_q, ctrl_l_d;
    logic [RA_W-1:0] rd_l_q, rd_l_d;
    logic [XLEN-1:0] regb_l_q, regb_l_d;
    logic [XLEN-1:0] tgt_l_q, tgt_l_d;

    logic [XLEN-1:0] b_op;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] mul_product;
    ctrl_t           ctrl_in;
    logic            is_mul;
    logic            slot_free;
    logic            accept;
    logic            mul_start;
    logic            mul_done;

    // Operand select and combinational ALU. With the multiplier disabled
    // the MUL code falls back to ADD.
    always_comb begin
        b_op       = alu_src ? imm : reg_b;
        target     = pc + imm;
        alu_result = '0;
        case (alu_op)
            C_AND:   alu_result = reg_a & b_op;
            C_OR:    alu_result = reg_a | b_op;
            C_ADD:   alu_result = reg_a + b_op;
            C_SUB:   alu_result = reg_a - b_op;
            C_PASSB: alu_result = b_op;
            C_MUL:   alu_result = (MUL_EN != 0) ? '0 : reg_a + b_op;
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        ctrl_in.reg_write     = reg_write;
        ctrl_in.branch        = branch;
        ctrl_in.uncond_branch = uncond_branch;
        ctrl_in.mem_read      = mem_read;
        ctrl_in.mem_write     = mem_write;
        ctrl_in.mem2reg       = mem2reg;
    end

    assign is_mul    = (MUL_EN != 0) && (alu_op == C_MUL);
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == IDLE) && slot_free && !flush;
    assign accept    = in_valid && in_ready;

    iter_mul #(
        .XLEN(XLEN)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .kill    (flush),
        .a       (reg_a),
        .b       (b_op),
        .done    (mul_done),
        .product (mul_product)
    );

    // Next-state and output-register logic. Flush overrides everything;
    // otherwise the register loads either a fresh ALU result or a finished
    // multiply, and drains to a bubble when consumed with nothing to load.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        ctrl_m_d    = ctrl_m_q;
        zero_m_d    = zero_m_q;
        rd_m_d      = rd_m_q;
        alu_m_d     = alu_m_q;
        regb_m_d    = regb_m_q;
        tgt_m_d     = tgt_m_q;
        ctrl_l_d    = ctrl_l_q;
        rd_l_d      = rd_l_q;
        regb_l_d    = regb_l_q;
        tgt_l_d     = tgt_l_q;
        mul_start   = 1'b0;

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            ctrl_m_d    = CTRL_NONE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && is_mul) begin
                        mul_start = 1'b1;
                        state_d   = BUSY;
                        ctrl_l_d  = ctrl_in;
                        rd_l_d    = rd;
                        regb_l_d  = reg_b;
                        tgt_l_d   = target;
                    end
                end
                BUSY: begin
                    if (mul_done) begin
                        state_d = slot_free ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (slot_free) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (accept && !is_mul) begin
                out_valid_d = 1'b1;
                ctrl_m_d    = ctrl_in;
                zero_m_d    = (alu_result == '0);
                rd_m_d      = rd;
                alu_m_d     = alu_result;
                regb_m_d    = reg_b;
                tgt_m_d     = target;
            end else if (((state_q == BUSY && mul_done) || state_q == DONE) && slot_free) begin
                out_valid_d = 1'b1;
                ctrl_m_d    = ctrl_l_q;
                zero_m_d    = (mul_product == '0);
                rd_m_d      = rd_l_q;
                alu_m_d     = mul_product;
                regb_m_d    = regb_l_q;
                tgt_m_d     = tgt_l_q;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
                ctrl_m_d    = CTRL_NONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            ctrl_m_q    <= CTRL_NONE;
            zero_m_q    <= 1'b0;
            rd_m_q      <= '0;
            alu_m_q     <= '0;
            regb_m_q    <= '0;
            tgt_m_q     <= '0;
            ctrl_l_q    <= CTRL_NONE;
            rd_l_q      <= '0;
            regb_l_q    <= '0;
            tgt_l_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            ctrl_m_q    <= ctrl_m_d;
            zero_m_q    <= zero_m_d;
            rd_m_q      <= rd_m_d;
            alu_m_q     <= alu_m_d;
            regb_m_q    <= regb_m_d;
            tgt_m_q     <= tgt_m_d;
            ctrl_l_q    <= ctrl_l_d;
            rd_l_q      <= rd_l_d;
            regb_l_q    <= regb_l_d;
            tgt_l_q     <= tgt_l_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign reg_write_m     = ctrl_m_q.reg_write;
    assign branch_m        = ctrl_m_q.branch;
    assign uncond_branch_m = ctrl_m_q.uncond_branch;
    assign mem_read_m      = ctrl_m_q.mem_read;
    assign mem_write_m     = ctrl_m_q.mem_write;
    assign mem2reg_m       = ctrl_m_q.mem2reg;
    assign alu_zero_m      = zero_m_q;
    assign rd_m            = rd_m_q;
    assign alu_out_m       = alu_m_q;
    assign reg_b_m         = regb_m_q;
    assign pc_target_m     = tgt_m_q;
    assign busy            = (MUL_EN != 0) ? (state_q != IDLE) : 1'b0;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Self-checking bench for exec_stage_mc (XLEN=64).
// Vectors from a table are driven through the input handshake; expected
// records go into a scoreboard queue and are compared whenever the output
// register is consumed. Hand-written sequences cover multiply latency,
// back-pressure, flush and asynchronous reset.
module tb_exec_stage_mc;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        logic [63:0] pc;
        logic        src;
        logic [4:0]  rd;
        logic [5:0]  ctrl;
        logic [63:0] exp_alu;
    } vec_t;

    typedef struct {
        logic [63:0] alu;
        logic        zero;
        logic [4:0]  rd;
        logic [63:0] regb;
        logic [63:0] tgt;
        logic [5:0]  ctrl;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        reg_write, branch, uncond_branch, mem_read, mem_write, mem2reg, alu_src;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic [63:0] reg_a, reg_b, imm, pc;
    logic        out_valid;
    logic        out_ready;
    logic        reg_write_m, branch_m, uncond_branch_m, mem_read_m, mem_write_m, mem2reg_m;
    logic        alu_zero_m;
    logic [4:0]  rd_m;
    logic [63:0] alu_out_m, reg_b_m, pc_target_m;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];
    vec_t v;

    exec_stage_mc #(
        .XLEN(64), .RA_W(5), .OP_W(4), .MUL_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .reg_write(reg_write), .branch(branch), .uncond_branch(uncond_branch),
        .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg),
        .alu_src(alu_src), .alu_op(alu_op), .rd(rd),
        .reg_a(reg_a), .reg_b(reg_b), .imm(imm), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_write_m(reg_write_m), .branch_m(branch_m), .uncond_branch_m(uncond_branch_m),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .mem2reg_m(mem2reg_m),
        .alu_zero_m(alu_zero_m), .rd_m(rd_m), .alu_out_m(alu_out_m),
        .reg_b_m(reg_b_m), .pc_target_m(pc_target_m), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and record the outcome
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Put a vector on the input pins without touching in_valid
    task automatic driveVec(input vec_t vv);
        alu_op = vv.op;
        reg_a  = vv.a;
        reg_b  = vv.b;
        imm    = vv.imm;
        pc     = vv.pc;
        alu_src = vv.src;
        rd     = vv.rd;
        {reg_write, branch, uncond_branch, mem_read, mem_write, mem2reg} = vv.ctrl;
    endtask

    function automatic exp_t expOf(input vec_t vv);
        exp_t e;
        e.alu  = vv.exp_alu;
        e.zero = (vv.exp_alu == 64'd0);
        e.rd   = vv.rd;
        e.regb = vv.b;
        e.tgt  = vv.pc + vv.imm;
        e.ctrl = vv.ctrl;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge
    task automatic applyStimulus(input vec_t vv, input bit push);
        int budget;
        driveVec(vv);
        in_valid = 1'b1;
        budget = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget++;
            if (budget > 300) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout in_ready=%b required=1", in_ready);
                break;
            end
        end
        if (push) sb.push_back(expOf(vv));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: every consumed output must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output alu_out_m=%h required=none", alu_out_m);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sb_alu_out",   alu_out_m,   mon_e.alu);
                checkOutput("sb_zero",      64'(alu_zero_m), 64'(mon_e.zero));
                checkOutput("sb_rd",        64'(rd_m),   64'(mon_e.rd));
                checkOutput("sb_reg_b",     reg_b_m,     mon_e.regb);
                checkOutput("sb_pc_target", pc_target_m, mon_e.tgt);
                checkOutput("sb_ctrl",
                    64'({reg_write_m, branch_m, uncond_branch_m, mem_read_m, mem_write_m, mem2reg_m}),
                    64'(mon_e.ctrl));
            end
        end
    end

    initial begin
        int lat, low, high, seen;

        vecs[0] = '{4'b0010, 64'd5, 64'd7, 64'd0, 64'd0, 1'b0, 5'd1, 6'b100000, 64'd12};
        vecs[1] = '{4'b0110, 64'd9, 64'hFFFF, 64'd9, 64'h100, 1'b1, 5'd2, 6'b010000, 64'd0};
        vecs[2] = '{4'b0000, 64'hF0F0, 64'hFF00, 64'd0, 64'h40, 1'b0, 5'd3, 6'b100001, 64'hF000};
        vecs[3] = '{4'b0001, 64'hF0F0, 64'h0F0F, 64'd4, 64'h40, 1'b0, 5'd4, 6'b000100, 64'hFFFF};
        vecs[4] = '{4'b0111, 64'd123, 64'd55, 64'hFFFF_FFFF_FFFF_FFFE, 64'h200, 1'b1, 5'd5, 6'b000010, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[5] = '{4'b0110, 64'd3, 64'd5, 64'd0, 64'h10, 1'b0, 5'd6, 6'b001000, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[6] = '{4'b0011, 64'd1, 64'd2, 64'd0, 64'd0, 1'b0, 5'd7, 6'b100000, 64'd0};
        vecs[7] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'h8, 1'b0, 5'd8, 6'b100000, 64'd0};
        vecs[8] = '{4'b0010, 64'd100, 64'd77, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1000, 1'b1, 5'd9, 6'b100001, 64'd96};
        vecs[9] = '{4'b1111, 64'd6, 64'd6, 64'd0, 64'd0, 1'b0, 5'd10, 6'b000000, 64'd0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        driveVec('{4'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 5'd0, 6'd0, 64'd0});
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_alu_out", alu_out_m, 64'd0);
        checkOutput("rst_pc_target", pc_target_m, 64'd0);
        checkOutput("rst_ctrl", 64'({reg_write_m, branch_m, uncond_branch_m, mem_read_m, mem_write_m, mem2reg_m, alu_zero_m}), 64'd0);
        @(posedge clk); #1;

        // ADD 5+7: result one cycle after accept
        applyStimulus(vecs[0], 1'b1);
        @(negedge clk);
        checkOutput("add_latency_valid", 64'(out_valid), 64'd1);
        checkOutput("add_result", alu_out_m, 64'd12);
        @(posedge clk); #1;

        // Remaining table vectors back to back
        for (int i = 1; i < 10; i++) applyStimulus(vecs[i], 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // MUL 6x7: XLEN+1 cycles to the result, stage held off meanwhile
        v = '{4'b1000, 64'd6, 64'd7, 64'd0, 64'h300, 1'b0, 5'd11, 6'b100000, 64'd42};
        applyStimulus(v, 1'b1);
        lat = 0; low = 0; high = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            if (lat == 0) checkOutput("mul_busy", 64'(busy), 64'd1);
            if (in_ready) high++; else low++;
            if (lat > 200) begin
                checks++; errors++;
                $display("[TB] FAIL mul_timeout cycles=%0d required=65", lat);
                break;
            end
            @(posedge clk);
            lat++;
        end
        checkOutput("mul_latency", 64'(lat), 64'd65);
        checkOutput("mul_in_ready_high", 64'(high), 64'd0);
        checkOutput("mul_in_ready_low_ge64", 64'(low >= 64), 64'd1);
        checkOutput("mul_result", alu_out_m, 64'd42);
        @(posedge clk); #1;

        // Back-pressure: first ADD held for 3 cycles while a second waits
        out_ready = 1'b0;
        v = '{4'b0010, 64'd1, 64'd2, 64'd0, 64'h20, 1'b0, 5'd12, 6'b100000, 64'd3};
        applyStimulus(v, 1'b1);
        v = '{4'b0010, 64'd10, 64'd20, 64'd0, 64'h24, 1'b0, 5'd13, 6'b100001, 64'd30};
        driveVec(v);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_hold_alu", alu_out_m, 64'd3);
            checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_hold_rd", 64'(rd_m), 64'd12);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        sb.push_back(expOf(v));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_second_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_second_alu", alu_out_m, 64'd30);
        @(posedge clk); #1;

        // Flush at BUSY cycle 10 of MUL 3x4: result must never appear
        v = '{4'b1000, 64'd3, 64'd4, 64'd0, 64'h0, 1'b0, 5'd14, 6'b100000, 64'd12};
        applyStimulus(v, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy", 64'(busy), 64'd0);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_in_ready_after", 64'(in_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("flush_no_result", 64'(seen), 64'd0);
        @(posedge clk); #1;

        // Flush a held output while a new op is offered in the same cycle
        out_ready = 1'b0;
        v = '{4'b0010, 64'd2, 64'd2, 64'd0, 64'h0, 1'b0, 5'd15, 6'b100001, 64'd4};
        applyStimulus(v, 1'b0);
        v = '{4'b0010, 64'd8, 64'd8, 64'd0, 64'h0, 1'b0, 5'd16, 6'b100000, 64'd16};
        driveVec(v);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush2_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checkOutput("flush2_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush2_ctrl", 64'({reg_write_m, mem2reg_m}), 64'd0);
        checkOutput("flush2_data_hold", alu_out_m, 64'd4);
        @(posedge clk); #1;

        // Reset in the middle of a multiply
        v = '{4'b1000, 64'd6, 64'd7, 64'd0, 64'h0, 1'b0, 5'd17, 6'b100000, 64'd42};
        applyStimulus(v, 1'b0);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_mul_busy", 64'(busy), 64'd0);
        checkOutput("rst_mul_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mul_alu", alu_out_m, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Reset while a result is held
        out_ready = 1'b0;
        v = '{4'b0010, 64'd2, 64'd3, 64'd4, 64'h50, 1'b0, 5'd18, 6'b100000, 64'd5};
        applyStimulus(v, 1'b0);
        @(negedge clk);
        checkOutput("rst_hold_pre_valid", 64'(out_valid), 64'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_hold_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_hold_alu", alu_out_m, 64'd0);
        checkOutput("rst_hold_target", pc_target_m, 64'd0);
        checkOutput("rst_hold_rw", 64'(reg_write_m), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        out_ready = 1'b1;
        sb.delete();

        v = '{4'b0010, 64'd1, 64'd1, 64'd0, 64'h0, 1'b0, 5'd19, 6'b100000, 64'd2};
        applyStimulus(v, 1'b1);
        @(negedge clk);
        checkOutput("post_rst_add", alu_out_m, 64'd2);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
